// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: turns one control-FSM request into a fixed-length SRAM strobe window
// and returns a single-cycle ready pulse plus registered read data.
module mem_access_ctrl #(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Mem_En,
   input  logic              Rd_Wr,
   input  logic [ADDR_W-1:0] MAR_In,
   input  logic [DATA_W-1:0] MDR_In,
   output logic              Mem_Rdy,
   output logic [DATA_W-1:0] Data_To_CPU,
   output logic              Busy,
   output logic [ADDR_W-1:0] Sram_Addr,
   output logic [DATA_W-1:0] Sram_Wdata,
   input  logic [DATA_W-1:0] Sram_Rdata,
   output logic              Sram_CE,
   output logic              Sram_OE,
   output logic              Sram_WE
);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e     state;
   logic [3:0] wait_cnt;
   logic       is_write;

   // Strobes are set on entry to ACCESS so they are valid for the whole window.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state       <= StIdle;
         wait_cnt    <= 4'd0;
         is_write    <= 1'b0;
         Mem_Rdy     <= 1'b0;
         Busy        <= 1'b0;
         Sram_CE     <= 1'b0;
         Sram_OE     <= 1'b0;
         Sram_WE     <= 1'b0;
         Data_To_CPU <= '0;
         Sram_Addr   <= '0;
         Sram_Wdata  <= '0;
      end else begin
         case (state)
            StIdle: begin
               if (Mem_En) begin
                  Sram_Addr  <= MAR_In;
                  Sram_Wdata <= MDR_In;
                  is_write   <= Rd_Wr;
                  wait_cnt   <= 4'(WAIT_CYCLES);
                  Busy       <= 1'b1;
                  Sram_CE    <= 1'b1;
                  Sram_OE    <= ~Rd_Wr;
                  Sram_WE    <= Rd_Wr;
                  state      <= StAccess;
               end
            end
            StAccess: begin
               if (wait_cnt != 4'd0) begin
                  wait_cnt <= wait_cnt - 4'd1;
               end else begin
                  if (!is_write) begin
                     Data_To_CPU <= Sram_Rdata;
                  end
                  Sram_CE <= 1'b0;
                  Sram_OE <= 1'b0;
                  Sram_WE <= 1'b0;
                  Mem_Rdy <= 1'b1;
                  state   <= StDone;
               end
            end
            StDone: begin
               // Leave unconditionally; a held Mem_En is only seen again from IDLE.
               Mem_Rdy <= 1'b0;
               Busy    <= 1'b0;
               state   <= StIdle;
            end
            default: begin
               Mem_Rdy <= 1'b0;
               Busy    <= 1'b0;
               Sram_CE <= 1'b0;
               Sram_OE <= 1'b0;
               Sram_WE <= 1'b0;
               state   <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomised scoreboard bench for mem_access_ctrl with an SRAM model and a
// transaction-level reference memory.
module tb_mem_access_ctrl;

   localparam int W = 2;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Mem_En, Rd_Wr;
   logic [15:0] MAR_In, MDR_In;
   logic        Mem_Rdy, Busy, Sram_CE, Sram_OE, Sram_WE;
   logic [15:0] Data_To_CPU, Sram_Addr, Sram_Wdata, Sram_Rdata;

   logic        en0;
   logic        rw0;
   logic [15:0] addr0, wd0;
   logic        rdy0, busy0, ce0, oe0, we0;
   logic [15:0] dout0, sa0, sw0, rd0;

   logic [15:0] sram_mem [65536];
   logic [15:0] ref_mem  [65536];

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp;
      int          k;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          n_total = 0;
   int          n_bad = 0;
   int          acc_cnt = 0;
   int          rdy_cnt = 0;
   int          n_acc = 0;
   bit          mon_en = 1'b0;
   logic [15:0] last_read = 16'h0;

   mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W)) dut (
      .Clk(Clk), .Reset(Reset), .Mem_En(Mem_En), .Rd_Wr(Rd_Wr), .MAR_In(MAR_In),
      .MDR_In(MDR_In), .Mem_Rdy(Mem_Rdy), .Data_To_CPU(Data_To_CPU), .Busy(Busy),
      .Sram_Addr(Sram_Addr), .Sram_Wdata(Sram_Wdata), .Sram_Rdata(Sram_Rdata),
      .Sram_CE(Sram_CE), .Sram_OE(Sram_OE), .Sram_WE(Sram_WE)
   );

   mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(0)) dut0 (
      .Clk(Clk), .Reset(Reset), .Mem_En(en0), .Rd_Wr(rw0), .MAR_In(addr0),
      .MDR_In(wd0), .Mem_Rdy(rdy0), .Data_To_CPU(dout0), .Busy(busy0),
      .Sram_Addr(sa0), .Sram_Wdata(sw0), .Sram_Rdata(rd0),
      .Sram_CE(ce0), .Sram_OE(oe0), .Sram_WE(we0)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   // SRAM models
   assign Sram_Rdata = (Sram_CE && Sram_OE) ? sram_mem[Sram_Addr] : 16'h0;
   assign rd0        = (ce0 && oe0) ? (sa0 ^ 16'h5A5A) : 16'h0;

   always @(posedge Clk) begin
      if (Sram_CE && Sram_WE) sram_mem[Sram_Addr] = Sram_Wdata;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: pops the scoreboard on every ready pulse, checks the bus every cycle.
   always @(negedge Clk) begin
      if (mon_en) begin
         if (Mem_Rdy) begin
            exp_t e;
            rdy_cnt++;
            if (sb.size() == 0) begin
               chk("rdy_unexpected", 64'(Mem_Rdy), 64'd0);
            end else begin
               e = sb.pop_front();
               chk("latency", 64'(cyc), 64'(e.k + W + 1));
               chk("access_len", 64'(acc_cnt), 64'(W + 1));
               chk("rd_data", 64'(Data_To_CPU), 64'(e.exp));
               chk("done_strobes", 64'({Busy, Sram_CE, Sram_OE, Sram_WE}), 64'(4'b1000));
            end
            acc_cnt = 0;
         end else if (Busy) begin
            acc_cnt++;
            if (sb.size() == 0) begin
               chk("busy_unexpected", 64'(Busy), 64'd0);
            end else begin
               chk("access_bus", 64'({Sram_CE, Sram_OE, Sram_WE, Sram_Addr, Sram_Wdata}),
                   64'({1'b1, ~sb[0].wr, sb[0].wr, sb[0].addr, sb[0].wdata}));
            end
         end else begin
            acc_cnt = 0;
            chk("idle_strobes", 64'({Sram_CE, Sram_OE, Sram_WE}), 64'd0);
         end
      end
   end

   // Called at a negedge. Mode 0: drop Mem_En after acceptance, 1: hold it,
   // 2: churn inputs during ACCESS, 3: abort with Reset in the 2nd ACCESS cycle.
   // Returns at the DONE negedge (Mem_En left as is) or after an abort.
   task automatic issue(input bit wr, input logic [15:0] a, input logic [15:0] d, input int mode);
      exp_t e;
      int   t;
      Mem_En = 1'b1;
      Rd_Wr  = wr;
      MAR_In = a;
      MDR_In = d;
      t = 0;
      while (Busy && t < 8) begin
         @(negedge Clk);
         t++;
      end
      if (Busy) begin
         chk("accept_timeout", 64'(Busy), 64'd0);
         Mem_En = 1'b0;
         return;
      end
      e.wr    = wr;
      e.addr  = a;
      e.wdata = d;
      e.k     = cyc + 1;
      if (wr) begin
         ref_mem[a] = d;
         e.exp = last_read;
      end else begin
         e.exp = ref_mem[a];
         last_read = e.exp;
      end
      sb.push_back(e);
      n_acc++;
      @(negedge Clk);
      for (int i = 0; i < 40; i++) begin
         if (Mem_Rdy) return;
         if (mode == 3 && i == 1) begin
            Reset  = 1'b1;
            Mem_En = 1'b0;
            @(negedge Clk);
            Reset = 1'b0;
            void'(sb.pop_back());
            n_acc--;
            last_read = 16'h0;
            chk("abort_state",
                64'({Mem_Rdy, Busy, Sram_CE, Sram_OE, Sram_WE, Data_To_CPU, Sram_Addr}), 64'd0);
            chk("abort_wdata", 64'(Sram_Wdata), 64'd0);
            return;
         end
         case (mode)
            0: Mem_En = 1'b0;
            2: begin
               Mem_En = 1'($urandom % 2);
               Rd_Wr  = 1'($urandom % 2);
               MAR_In = (i == 0) ? 16'hFFFF : 16'($urandom);
               MDR_In = 16'($urandom);
            end
            default: ;
         endcase
         @(negedge Clk);
      end
      chk("rdy_timeout", 64'(Mem_Rdy), 64'd1);
   endtask

   initial begin
      logic [15:0] v;
      bit          wr;
      logic [15:0] a;
      int          r, mode, k0;
      for (int i = 0; i < 65536; i++) begin
         v = 16'(i);
         sram_mem[i] = {v[7:0], ~v[15:8]};
         ref_mem[i]  = {v[7:0], ~v[15:8]};
      end
      sram_mem[16'h3000] = 16'hBEEF;
      ref_mem[16'h3000]  = 16'hBEEF;

      Reset = 1'b1; Mem_En = 1'b0; Rd_Wr = 1'b0; MAR_In = 16'h0; MDR_In = 16'h0;
      en0 = 1'b0; rw0 = 1'b0; addr0 = 16'h0; wd0 = 16'h0;
      repeat (3) @(negedge Clk);
      chk("reset_state",
          64'({Mem_Rdy, Busy, Sram_CE, Sram_OE, Sram_WE, Data_To_CPU, Sram_Addr}), 64'd0);
      chk("reset_wdata", 64'(Sram_Wdata), 64'd0);
      Reset = 1'b0;
      @(negedge Clk);
      mon_en = 1'b1;

      // Zero-wait instance: single-cycle ACCESS, ready on the next cycle.
      en0 = 1'b1; addr0 = 16'h0001;
      k0 = cyc + 1;
      @(negedge Clk);
      en0 = 1'b0;
      chk("w0_access", 64'({busy0, ce0, oe0, we0, sa0}), 64'({4'b1110, 16'h0001}));
      @(negedge Clk);
      chk("w0_rdy", 64'({rdy0, ce0, oe0, we0}), 64'(4'b1000));
      chk("w0_latency", 64'(cyc), 64'(k0 + 1));
      chk("w0_data", 64'(dout0), 64'(16'h5A5B));
      @(negedge Clk);
      chk("w0_idle", 64'({rdy0, busy0}), 64'd0);

      // Directed scenarios
      issue(1'b0, 16'h3000, 16'h0000, 0);
      Mem_En = 1'b0; repeat (2) @(negedge Clk);
      issue(1'b1, 16'h1234, 16'hA5A5, 0);
      Mem_En = 1'b0; @(negedge Clk);
      issue(1'b0, 16'h1234, 16'h0000, 1);
      issue(1'b0, 16'h1234, 16'h0000, 1);
      Mem_En = 1'b0; @(negedge Clk);
      issue(1'b0, 16'h3000, 16'h0000, 2);
      Mem_En = 1'b0;
      chk("addr_hold", 64'(Sram_Addr), 64'(16'h3000));
      @(negedge Clk);
      issue(1'b0, 16'h3000, 16'h0000, 3);
      issue(1'b0, 16'h1234, 16'h0000, 0);
      Mem_En = 1'b0; @(negedge Clk);

      // Randomised traffic
      for (int n = 0; n < 150; n++) begin
         wr = 1'($urandom % 2);
         a  = ($urandom % 4 == 0) ? 16'($urandom) : (16'h4000 | 16'($urandom % 16));
         r  = int'($urandom % 10);
         mode = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
         issue(wr, a, 16'($urandom), mode);
         if ($urandom % 2 == 1) begin
            Mem_En = 1'b0;
            repeat ($urandom % 3) @(negedge Clk);
         end
      end

      Mem_En = 1'b0;
      repeat (8) @(negedge Clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      chk("rdy_count", 64'(rdy_cnt), 64'(n_acc));
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
